// File: rtl/branch_pkg.sv
// Shared types and the 2-bit saturating counter helper for the global branch predictor.
package branch_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } sched_state_e;

  function automatic logic [1:0] sat2_next(input logic [1:0] cnt, input logic taken);
    if (taken) return (cnt == 2'b11) ? 2'b11 : cnt + 2'd1;
    else       return (cnt == 2'b00) ? 2'b00 : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/branch_upd_fifo.sv
// 1-bit resolved-outcome FIFO; a pop in the same cycle frees a slot for a push when full.
module branch_upd_fifo #(
  parameter int QDEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enq_val,
  output logic enq_rdy,
  input  logic enq_data,
  output logic deq_val,
  input  logic deq_rdy,
  output logic deq_data,
  output logic full
);

  localparam int PW = $clog2(QDEPTH);
  localparam logic [PW:0] PTR_ONE = 1;

  logic [PW:0]       wr_ptr_q, wr_ptr_d;
  logic [PW:0]       rd_ptr_q, rd_ptr_d;
  logic [QDEPTH-1:0] mem_q, mem_d;
  logic              empty, do_enq, do_deq;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign deq_val  = !empty;
  assign deq_data = mem_q[rd_ptr_q[PW-1:0]];
  assign do_deq   = deq_rdy && !empty;
  assign enq_rdy  = !full || do_deq;
  assign do_enq   = enq_val && enq_rdy;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (do_enq) begin
      mem_d[wr_ptr_q[PW-1:0]] = enq_data;
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (do_deq) rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      mem_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/branch_pht_sched.sv
// Single-port PHT arbiter, GHR owner and post-reset PHT clear sweep for the global predictor.
// Optional BRANCH_PHT_SCHED_STATS_EN adds stall / forced-update counters.
//
//   state | meaning
//   INIT  | sweeping every PHT entry to weakly-not-taken; lookups blocked
//   RUN   | one lookup or one queued update per cycle
module branch_pht_sched
  import branch_pkg::*;
#(
  parameter int PHT_SIZE   = 2048,
  parameter int QDEPTH     = 4,
  parameter int STARVE_MAX = 3,
  localparam int AW        = $clog2(PHT_SIZE)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          lkup_val,
  output logic          lkup_rdy,
  output logic          lkup_taken,
  input  logic          upd_val,
  output logic          upd_rdy,
  input  logic          upd_taken,
  output logic [AW-1:0] pht_addr,
  input  logic [1:0]    pht_rdata,
  output logic          pht_wen,
  output logic [1:0]    pht_wdata,
  output logic          busy
`ifdef BRANCH_PHT_SCHED_STATS_EN
  ,
  output logic [31:0]   stat_lkup_stall,
  output logic [31:0]   stat_forced
`endif
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  sched_state_e  state_q, state_d;
  logic [AW-1:0] sweep_cnt_q, sweep_cnt_d;
  logic [AW-1:0] ghr_q, ghr_d;
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;

  logic q_enq_rdy, q_deq_val, q_head, q_full, q_pop;
  logic force_upd, upd_grant, lkup_grant;

  branch_upd_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .enq_val  (upd_val),
    .enq_rdy  (q_enq_rdy),
    .enq_data (upd_taken),
    .deq_val  (q_deq_val),
    .deq_rdy  (q_pop),
    .deq_data (q_head),
    .full     (q_full)
  );

  assign busy    = (state_q == INIT);
  assign upd_rdy = reset && q_enq_rdy;

  always_comb begin
    state_d      = state_q;
    sweep_cnt_d  = sweep_cnt_q;
    ghr_d        = ghr_q;
    starve_cnt_d = starve_cnt_q;
    lkup_rdy     = 1'b0;
    lkup_taken   = 1'b0;
    pht_addr     = '0;
    pht_wen      = 1'b0;
    pht_wdata    = 2'b00;
    q_pop        = 1'b0;
    force_upd    = 1'b0;
    upd_grant    = 1'b0;
    lkup_grant   = 1'b0;
    case (state_q)
      INIT: begin
        pht_wen     = 1'b1;
        pht_addr    = sweep_cnt_q;
        pht_wdata   = 2'b01;
        sweep_cnt_d = sweep_cnt_q + AW'(1);
        if (sweep_cnt_q == AW'(PHT_SIZE - 1)) state_d = RUN;
      end
      RUN: begin
        force_upd  = q_full || (starve_cnt_q == SW'(STARVE_MAX) && q_deq_val);
        upd_grant  = q_deq_val && (force_upd || !lkup_val);
        lkup_grant = lkup_val && !upd_grant;
        pht_addr   = ghr_q;
        if (upd_grant) begin
          q_pop        = 1'b1;
          pht_wen      = 1'b1;
          pht_wdata    = sat2_next(pht_rdata, q_head);
          ghr_d        = {ghr_q[AW-2:0], q_head};
          starve_cnt_d = '0;
        end else if (lkup_grant) begin
          lkup_rdy     = 1'b1;
          lkup_taken   = pht_rdata[1];
          starve_cnt_d = q_deq_val ? starve_cnt_q + SW'(1) : '0;
        end
      end
      default: state_d = INIT;
    endcase
    // Outputs stay quiet while reset is held, even though the state already reads INIT.
    if (!reset) begin
      pht_wen   = 1'b0;
      pht_wdata = 2'b00;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= INIT;
      sweep_cnt_q  <= '0;
      ghr_q        <= '0;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      sweep_cnt_q  <= sweep_cnt_d;
      ghr_q        <= ghr_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

`ifdef BRANCH_PHT_SCHED_STATS_EN
  logic [31:0] stall_q, stall_d, forced_q, forced_d;

  always_comb begin
    stall_d  = stall_q;
    forced_d = forced_q;
    if (state_q == RUN && lkup_val && !lkup_rdy) stall_d = stall_q + 32'd1;
    if (upd_grant && force_upd) forced_d = forced_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q  <= '0;
      forced_q <= '0;
    end else begin
      stall_q  <= stall_d;
      forced_q <= forced_d;
    end
  end

  assign stat_lkup_stall = stall_q;
  assign stat_forced     = forced_q;
`endif

endmodule

// File: tb/tb_branch_pht_sched.sv
// Directed bench for branch_pht_sched with a 16-entry PHT modelled as a bench-side array.
module tb_branch_pht_sched;

  localparam int PHT_SIZE   = 16;
  localparam int QDEPTH     = 4;
  localparam int STARVE_MAX = 3;
  localparam int AW         = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          lkup_val, lkup_rdy, lkup_taken;
  logic          upd_val, upd_rdy, upd_taken;
  logic [AW-1:0] pht_addr;
  logic [1:0]    pht_rdata;
  logic          pht_wen;
  logic [1:0]    pht_wdata;
  logic          busy;
`ifdef BRANCH_PHT_SCHED_STATS_EN
  logic [31:0]   stat_lkup_stall, stat_forced;
`endif

  logic [1:0]    mem [PHT_SIZE];
  logic          preload_en = 1'b0;
  logic [1:0]    preload_val = 2'b00;

  int n_chk  = 0;
  int n_fail = 0;
  logic [AW-1:0] ghr_m;
  int            fill_cnt;

  typedef struct packed {
    logic [1:0] cnt;
    logic       taken;
    logic [1:0] exp;
  } sat_vec_t;
  sat_vec_t vecs [8];

  branch_pht_sched #(
    .PHT_SIZE  (PHT_SIZE),
    .QDEPTH    (QDEPTH),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .lkup_val  (lkup_val),
    .lkup_rdy  (lkup_rdy),
    .lkup_taken(lkup_taken),
    .upd_val   (upd_val),
    .upd_rdy   (upd_rdy),
    .upd_taken (upd_taken),
    .pht_addr  (pht_addr),
    .pht_rdata (pht_rdata),
    .pht_wen   (pht_wen),
    .pht_wdata (pht_wdata),
    .busy      (busy)
`ifdef BRANCH_PHT_SCHED_STATS_EN
    ,
    .stat_lkup_stall(stat_lkup_stall),
    .stat_forced    (stat_forced)
`endif
  );

  always #5 clk = ~clk;

  assign pht_rdata = mem[pht_addr];

  always @(posedge clk) begin
    if (preload_en) begin
      for (int k = 0; k < PHT_SIZE; k++) mem[k] <= preload_val;
    end else if (pht_wen) begin
      mem[pht_addr] <= pht_wdata;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic lv, input logic uv, input logic ut);
    lkup_val  = lv;
    upd_val   = uv;
    upd_taken = ut;
  endtask

  initial begin
    vecs[0] = '{cnt: 2'b00, taken: 1'b0, exp: 2'b00};
    vecs[1] = '{cnt: 2'b00, taken: 1'b1, exp: 2'b01};
    vecs[2] = '{cnt: 2'b01, taken: 1'b0, exp: 2'b00};
    vecs[3] = '{cnt: 2'b01, taken: 1'b1, exp: 2'b10};
    vecs[4] = '{cnt: 2'b10, taken: 1'b0, exp: 2'b01};
    vecs[5] = '{cnt: 2'b10, taken: 1'b1, exp: 2'b11};
    vecs[6] = '{cnt: 2'b11, taken: 1'b0, exp: 2'b10};
    vecs[7] = '{cnt: 2'b11, taken: 1'b1, exp: 2'b11};

    // Reset held; PHT pre-filled with 11 so the sweep is visible.
    reset = 1'b0;
    drive(0, 0, 0);
    preload_en  = 1'b1;
    preload_val = 2'b11;
    next();
    preload_en = 1'b0;
    drive(1, 1, 1);
    @(negedge clk);
    chk("rst_busy", busy, 1);
    chk("rst_wen", pht_wen, 0);
    chk("rst_wdata", pht_wdata, 0);
    chk("rst_upd_rdy", upd_rdy, 0);
    chk("rst_lkup_rdy", lkup_rdy, 0);
    chk("rst_addr", pht_addr, 0);
    next();

    // INIT sweep: exactly PHT_SIZE cycles writing 01 to 0..15.
    reset = 1'b1;
    drive(1, 0, 0);
    for (int i = 0; i < PHT_SIZE; i++) begin
      @(negedge clk);
      chk($sformatf("init_busy_%0d", i), busy, 1);
      chk($sformatf("init_wen_%0d", i), pht_wen, 1);
      chk($sformatf("init_addr_%0d", i), pht_addr, i);
      chk($sformatf("init_wdata_%0d", i), pht_wdata, 2'b01);
      chk($sformatf("init_lkup_rdy_%0d", i), lkup_rdy, 0);
      next();
    end

    // First RUN cycle: zero-latency lookup at GHR=0.
    @(negedge clk);
    chk("run_busy", busy, 0);
    chk("lk0_rdy", lkup_rdy, 1);
    chk("lk0_taken", lkup_taken, 0);
    chk("lk0_wen", pht_wen, 0);
    chk("lk0_addr", pht_addr, 0);
    fill_cnt = 0;
    for (int k = 0; k < PHT_SIZE; k++) if (mem[k] == 2'b01) fill_cnt++;
    chk("sweep_fill", fill_cnt, PHT_SIZE);
    next();

    // Three taken updates on an idle bus.
    ghr_m = '0;
    drive(0, 1, 1);
    @(negedge clk);
    chk("t3_idle_wen", pht_wen, 0);
    chk("t3_upd_rdy", upd_rdy, 1);
    next();
    for (int k = 0; k < 3; k++) begin
      drive(0, (k < 2), 1);
      @(negedge clk);
      chk($sformatf("t3_wen_%0d", k), pht_wen, 1);
      chk($sformatf("t3_addr_%0d", k), pht_addr, ghr_m);
      chk($sformatf("t3_wdata_%0d", k), pht_wdata, 2'b10);
      next();
      ghr_m = {ghr_m[AW-2:0], 1'b1};
    end
    drive(0, 0, 0);
    @(negedge clk);
    chk("t3_mem0", mem[0], 2'b10);
    chk("t3_mem1", mem[1], 2'b10);
    chk("t3_mem3", mem[3], 2'b10);
    chk("t3_idle_after", pht_wen, 0);
    next();

    // Starvation: push one update under constant lookups.
    drive(1, 1, 0);
    @(negedge clk);
    chk("t4_push_lk_rdy", lkup_rdy, 1);
    chk("t4_push_addr", pht_addr, 4'b0111);
    next();
    for (int k = 0; k < STARVE_MAX; k++) begin
      drive(1, 0, 0);
      @(negedge clk);
      chk($sformatf("t4_lk_rdy_%0d", k), lkup_rdy, 1);
      chk($sformatf("t4_lk_wen_%0d", k), pht_wen, 0);
      next();
    end
    @(negedge clk);
    chk("t4_force_lk_rdy", lkup_rdy, 0);
    chk("t4_force_taken", lkup_taken, 0);
    chk("t4_force_wen", pht_wen, 1);
    chk("t4_force_addr", pht_addr, ghr_m);
    chk("t4_force_wdata", pht_wdata, 2'b00);
    next();
    ghr_m = {ghr_m[AW-2:0], 1'b0};
    @(negedge clk);
    chk("t4_after_lk_rdy", lkup_rdy, 1);
    chk("t4_after_addr", pht_addr, 4'b1110);
    chk("t4_after_taken", lkup_taken, 0);
    next();

    // Saturating counter table.
    for (int v = 0; v < 8; v++) begin
      drive(0, 0, 0);
      preload_en  = 1'b1;
      preload_val = vecs[v].cnt;
      next();
      preload_en = 1'b0;
      drive(0, 1, vecs[v].taken);
      @(negedge clk);
      chk($sformatf("sat%0d_push_rdy", v), upd_rdy, 1);
      chk($sformatf("sat%0d_push_wen", v), pht_wen, 0);
      next();
      drive(0, 0, 0);
      @(negedge clk);
      chk($sformatf("sat%0d_wen", v), pht_wen, 1);
      chk($sformatf("sat%0d_addr", v), pht_addr, ghr_m);
      chk($sformatf("sat%0d_wdata", v), pht_wdata, vecs[v].exp);
      next();
      ghr_m = {ghr_m[AW-2:0], vecs[v].taken};
    end

    // Queue three updates behind lookups, then reset mid-drain.
    drive(1, 1, 1);
    next();
    next();
    next();
    reset = 1'b0;
    @(negedge clk);
    chk("rst2_busy", busy, 1);
    chk("rst2_wen", pht_wen, 0);
    chk("rst2_upd_rdy", upd_rdy, 0);
    chk("rst2_lkup_rdy", lkup_rdy, 0);
    next();
    next();
    reset = 1'b1;
    ghr_m = '0;

    // Second INIT: four pushes fill an empty queue, fifth is refused.
    for (int i = 0; i < PHT_SIZE; i++) begin
      @(negedge clk);
      chk($sformatf("init2_upd_rdy_%0d", i), upd_rdy, (i < QDEPTH));
      chk($sformatf("init2_addr_%0d", i), pht_addr, i);
      chk($sformatf("init2_busy_%0d", i), busy, 1);
      next();
    end
    @(negedge clk);
    chk("t5_busy", busy, 0);
    chk("t5_lkup_rdy", lkup_rdy, 0);
    chk("t5_wen", pht_wen, 1);
    chk("t5_addr", pht_addr, ghr_m);
    chk("t5_wdata", pht_wdata, 2'b10);
    chk("t5_full_pop_rdy", upd_rdy, 1);
    next();
    drive(0, 0, 0);
    repeat (8) next();
    drive(1, 0, 0);
    @(negedge clk);
    chk("drain_lk_rdy", lkup_rdy, 1);
    chk("drain_wen", pht_wen, 0);
    chk("drain_ghr", pht_addr, 4'b1111);
    chk("drain_upd_rdy", upd_rdy, 1);
    next();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
